// File: rtl/s38417_stim_pkg.sv
// Shared types and constants for the s38417 n3574 cone self-test driver.
// Latency: n/a (types, constants and a pure LFSR step function only).
// Backpressure: n/a.
package s38417_stim_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    SETTLE,
    CAPTURE,
    DONE
  } state_t;

  // Galois taps for the right-shifting 32-bit pattern LFSR.
  localparam logic [31:0] LFSR_TAPS = 32'hA300_0000;

  // Feedback polynomial for the 16-bit response MISR.
  localparam logic [15:0] MISR_POLY = 16'h1021;

  // One LFSR advance: shift right, fold the taps back in when a 1 falls out.
  function automatic logic [31:0] lfsr_step(input logic [31:0] cur);
    return cur[0] ? ((cur >> 1) ^ LFSR_TAPS) : (cur >> 1);
  endfunction

endpackage

// File: rtl/stim_misr.sv
// Response compactor: W-bit multiple-input signature register fed by one response bit.
// Latency: signature reflects din one edge after an enabled cycle.
// Backpressure: none; updates only when en is high, clr has priority over en.
//
// Ports:
//   clk  in   rising-edge clock
//   rst  in   synchronous active-high reset, clears the signature
//   en   in   fold din into the signature on this edge
//   clr  in   clear the signature on this edge (start of a new run)
//   din  in   response bit, XORed into bit 0 only
//   sig  out  current signature
module stim_misr
  import s38417_stim_pkg::*;
#(
  parameter int           W    = 16,
  parameter logic [W-1:0] POLY = W'(MISR_POLY)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic         din,
  output logic [W-1:0] sig
);

  always_ff @(posedge clk) begin
    if (rst) begin
      sig <= '0;
    end else if (clr) begin
      sig <= '0;
    end else if (en) begin
      // Shift left, apply polynomial feedback from the MSB, inject the response at bit 0.
      sig <= {sig[W-2:0], 1'b0} ^ (sig[W-1] ? POLY : '0) ^ W'(din);
    end
  end

endmodule

// File: rtl/s38417_n3574_stim.sv
// Self-test driver for the s38417 n3574 cone: serially loads LFSR patterns, samples resp, compacts into a MISR.
// Latency: VEC_W+2 cycles per pattern; done rises NPAT*(VEC_W+2) edges after the start edge.
// Backpressure: start is level-sampled only in IDLE/DONE and ignored while busy.
//
// Ports:
//   CK         in   rising-edge clock
//   RST        in   synchronous active-high reset, aborts any run
//   start      in   run request
//   resp       in   cone response bit, meaningful during CAPTURE only
//   stim       out  cone input vector, stim[0]=g2896 ... stim[VEC_W-1]=g930
//   busy       out  run in progress
//   done       out  run complete, held until the next start or RST
//   signature  out  MISR contents
//   pat_idx    out  current pattern index, zero-extended
module s38417_n3574_stim
  import s38417_stim_pkg::*;
#(
  parameter int          VEC_W  = 60,
  parameter int          NPAT   = 256,
  parameter logic [31:0] SEED   = 32'h1,
  parameter int          MISR_W = 16
) (
  input  logic              CK,
  input  logic              RST,
  input  logic              start,
  input  logic              resp,
  output logic [VEC_W-1:0]  stim,
  output logic              busy,
  output logic              done,
  output logic [MISR_W-1:0] signature,
  output logic [15:0]       pat_idx
);

  // An all-zero seed would lock the LFSR at zero, so it is replaced by 1.
  localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;

  localparam int CNT_W = $clog2(VEC_W + 1);
  localparam int PI_W  = (NPAT > 1) ? $clog2(NPAT) : 1;

  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(VEC_W - 1);
  localparam logic [PI_W-1:0]  LAST_PAT   = PI_W'(NPAT - 1);

  state_t            state;
  state_t            state_n;
  logic [31:0]       lfsr;
  logic [CNT_W-1:0]  shift_cnt;
  logic [PI_W-1:0]   pat;
  logic              run_start;
  logic              misr_en;

  // Next-state logic. run_start marks the edge that begins a new run and
  // drives all the per-run clearing (LFSR reload, counters, signature).
  always_comb begin
    state_n   = state;
    run_start = 1'b0;
    misr_en   = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n   = SHIFT;
          run_start = 1'b1;
        end
      end
      SHIFT: begin
        // shift_cnt counts completed shifts; this edge performs the VEC_W-th.
        if (shift_cnt == LAST_SHIFT) begin
          state_n = SETTLE;
        end
      end
      SETTLE: begin
        state_n = CAPTURE;
      end
      CAPTURE: begin
        misr_en = 1'b1;
        state_n = (pat == LAST_PAT) ? DONE : SHIFT;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      state     <= IDLE;
      stim      <= '0;
      lfsr      <= SEED_EFF;
      shift_cnt <= '0;
      pat       <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE, DONE: begin
          if (run_start) begin
            lfsr      <= SEED_EFF;
            shift_cnt <= '0;
            pat       <= '0;
          end
        end
        SHIFT: begin
          // Newest LFSR bit enters at stim[0]; the first bit of a pattern ends up at stim[VEC_W-1].
          stim      <= {stim[VEC_W-2:0], lfsr[0]};
          lfsr      <= lfsr_step(lfsr);
          shift_cnt <= shift_cnt + 1'b1;
        end
        CAPTURE: begin
          if (pat != LAST_PAT) begin
            pat       <= pat + 1'b1;
            shift_cnt <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  stim_misr #(
    .W    (MISR_W),
    .POLY (MISR_W'(MISR_POLY))
  ) u_misr (
    .clk (CK),
    .rst (RST),
    .en  (misr_en),
    .clr (run_start),
    .din (resp),
    .sig (signature)
  );

  assign busy    = (state == SHIFT) || (state == SETTLE) || (state == CAPTURE);
  assign done    = (state == DONE);
  assign pat_idx = 16'(pat);

endmodule

// File: tb/tb_s38417_n3574_stim.sv
// Bench for s38417_n3574_stim: three instances (NPAT=4 random resp, NPAT=2 tied resp, NPAT=256 SEED=0 with a stand-in cone).
// Expected values come from a pattern-stream/MISR model built from the LFSR and MISR rules.
// Responses are time-indexed from the start edge, so the model never looks at DUT state.
module tb_s38417_n3574_stim;

  localparam int VEC_W = 60;
  localparam int PLEN  = VEC_W + 2;
  localparam int NP_A  = 4;
  localparam int NP_B  = 2;
  localparam int NP_C  = 256;
  localparam int NBITS = NP_C * VEC_W;
  localparam logic [VEC_W-1:0] CONE_MASK = 60'hA5C3_96E1_B27D_04F;

  logic ck  = 1'b0;
  logic rst = 1'b1;
  always #5 ck = ~ck;

  int n_checks = 0;
  int n_fail   = 0;

  // Instance A: NPAT=4, random responses.
  logic             start_a = 1'b0;
  logic             resp_a  = 1'b0;
  logic [VEC_W-1:0] stim_a;
  logic             busy_a, done_a;
  logic [15:0]      sig_a, pidx_a;

  // Instance B: NPAT=2, tied responses.
  logic             start_b = 1'b0;
  logic             resp_b  = 1'b0;
  logic [VEC_W-1:0] stim_b;
  logic             busy_b, done_b;
  logic [15:0]      sig_b, pidx_b;

  // Instance C: NPAT=256, SEED=0, driven by a stand-in combinational cone.
  logic             start_c = 1'b0;
  logic             resp_c;
  logic [VEC_W-1:0] stim_c;
  logic             busy_c, done_c;
  logic [15:0]      sig_c, pidx_c;

  assign resp_c = ^(stim_c & CONE_MASK);

  s38417_n3574_stim #(.VEC_W(VEC_W), .NPAT(NP_A), .SEED(32'h1), .MISR_W(16)) u_dut_a (
    .CK(ck), .RST(rst), .start(start_a), .resp(resp_a), .stim(stim_a),
    .busy(busy_a), .done(done_a), .signature(sig_a), .pat_idx(pidx_a));

  s38417_n3574_stim #(.VEC_W(VEC_W), .NPAT(NP_B), .SEED(32'h1), .MISR_W(16)) u_dut_b (
    .CK(ck), .RST(rst), .start(start_b), .resp(resp_b), .stim(stim_b),
    .busy(busy_b), .done(done_b), .signature(sig_b), .pat_idx(pidx_b));

  s38417_n3574_stim #(.VEC_W(VEC_W), .NPAT(NP_C), .SEED(32'h0), .MISR_W(16)) u_dut_c (
    .CK(ck), .RST(rst), .start(start_c), .resp(resp_c), .stim(stim_c),
    .busy(busy_c), .done(done_c), .signature(sig_c), .pat_idx(pidx_c));

  // ---------------- reference model ----------------
  logic stream_bits [0:NBITS-1];   // LFSR output bit stream from seed 1
  logic rec_a [0:NP_A*PLEN];       // response applied before edge e of a run

  function automatic logic [VEC_W-1:0] exp_vec(input int k);
    logic [VEC_W-1:0] v;
    // Pattern k uses stream bits 60k..60k+59; the first one shifted ends at the MSB.
    for (int i = 0; i < VEC_W; i++) v[i] = stream_bits[k*VEC_W + VEC_W - 1 - i];
    return v;
  endfunction

  function automatic logic [15:0] misr_step(input logic [15:0] m, input logic r);
    logic [15:0] n;
    n = m << 1;
    if (m[15]) n = n ^ 16'h1021;
    n[0] = n[0] ^ r;
    return n;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One full run on instance A. replay=1 reuses the previous response sequence;
  // hold=1 leaves start asserted throughout.
  task automatic run_a(input bit replay, input bit hold, output logic [15:0] exp_sig);
    logic [15:0] m;
    m = 16'h0;
    start_a = 1'b1;
    @(posedge ck); #1;
    chk("a_busy_after_start", busy_a, 1);
    chk("a_done_cleared", done_a, 0);
    chk("a_sig_cleared", sig_a, 0);
    if (!hold) start_a = 1'b0;
    for (int e = 1; e <= NP_A*PLEN; e++) begin
      if (!replay) rec_a[e] = 1'($urandom_range(0, 1));
      resp_a = rec_a[e];
      if (e % PLEN == 0) begin
        // The cycle before edge 62(k+1) is the CAPTURE cycle of pattern k.
        int k;
        k = e / PLEN - 1;
        chk("a_stim_capture", stim_a, exp_vec(k));
        chk("a_pat_idx", pidx_a, k);
        chk("a_busy_mid", busy_a, 1);
      end
      if (e == NP_A*PLEN) chk("a_done_not_early", done_a, 0);
      @(posedge ck); #1;
      if (e % PLEN == 0) m = misr_step(m, rec_a[e]);
    end
    chk("a_done_on_time", done_a, 1);
    chk("a_busy_at_done", busy_a, 0);
    chk("a_signature", sig_a, m);
    exp_sig = m;
  endtask

  task automatic run_b(input logic r, output int edges);
    resp_b  = r;
    start_b = 1'b1;
    @(posedge ck); #1;
    start_b = 1'b0;
    edges = 0;
    while (!done_b && edges < 400) begin
      @(posedge ck); #1;
      edges++;
    end
  endtask

  initial begin
    logic [31:0] l;
    logic [15:0] s1, s2, s3, mc;
    int bad, eb;

    l = 32'h1;
    for (int i = 0; i < NBITS; i++) begin
      stream_bits[i] = l[0];
      l = l[0] ? ((l >> 1) ^ 32'hA300_0000) : (l >> 1);
    end

    // Reset held for three cycles, then idle with no start.
    rst = 1'b1;
    repeat (3) @(posedge ck);
    #1;
    chk("rst_stim", stim_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_sig", sig_a, 0);
    chk("rst_pidx", pidx_a, 0);
    rst = 1'b0;
    bad = 0;
    repeat (100) begin
      @(posedge ck); #1;
      if (busy_a || done_a || busy_b || busy_c || stim_a != '0 || sig_a != 16'h0) bad++;
    end
    chk("idle_quiet_100", bad, 0);

    // Tied responses on the two-pattern instance.
    run_b(1'b0, eb);
    chk("b_r0_done_edges", eb, 2*PLEN);
    chk("b_r0_sig", sig_b, 16'h0000);
    run_b(1'b1, eb);
    chk("b_r1_done_edges", eb, 2*PLEN);
    chk("b_r1_sig", sig_b, 16'h0003);
    chk("b_r1_stim", stim_b, exp_vec(1));

    // Random-response runs, then start held high across a run boundary.
    run_a(1'b0, 1'b0, s1);
    run_a(1'b0, 1'b1, s1);
    run_a(1'b1, 1'b0, s2);   // begins on the edge right after done rose
    chk("a_rerun_sig", sig_a, s1);

    // Abort in SETTLE of pattern 3, then an uninterrupted rerun.
    start_a = 1'b1;
    @(posedge ck); #1;
    start_a = 1'b0;
    repeat (3*PLEN + VEC_W) @(posedge ck);
    #1;
    chk("abort_busy_before", busy_a, 1);
    rst = 1'b1;
    @(posedge ck); #1;
    chk("abort_stim", stim_a, 0);
    chk("abort_busy", busy_a, 0);
    chk("abort_done", done_a, 0);
    chk("abort_sig", sig_a, 0);
    chk("abort_pidx", pidx_a, 0);
    rst = 1'b0;
    @(posedge ck); #1;
    run_a(1'b1, 1'b0, s3);
    chk("abort_rerun_sig", sig_a, s2);

    // Full 256-pattern run with SEED=0 against the stand-in cone.
    mc = 16'h0;
    for (int k = 0; k < NP_C; k++) mc = misr_step(mc, ^(exp_vec(k) & CONE_MASK));
    start_c = 1'b1;
    @(posedge ck); #1;
    start_c = 1'b0;
    repeat (NP_C*PLEN - 1) @(posedge ck);
    #1;
    chk("c_done_not_early", done_c, 0);
    @(posedge ck); #1;
    chk("c_done", done_c, 1);
    chk("c_pidx_last", pidx_c, NP_C - 1);
    chk("c_signature", sig_c, mc);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
